// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the power-sequencing controller.
package pwr_seq_pkg;

  typedef enum logic [3:0] {
    ST_ON,
    ST_ISO,
    ST_SAVE,
    ST_SW_OFF,
    ST_OFF,
    ST_SW_ON,
    ST_SETTLE,
    ST_RESTORE,
    ST_ISO_REL
  } pwr_seq_state_e;

  localparam logic [1:0] PS_ON         = 2'd0;
  localparam logic [1:0] PS_OFF        = 2'd1;
  localparam logic [1:0] PS_GOING_DOWN = 2'd2;
  localparam logic [1:0] PS_GOING_UP   = 2'd3;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// Loadable down-counter shared by all timed sequencer states; expire marks the last cycle.
module pwr_seq_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Power-sequencing controller for one switchable domain: isolate, save, switch off,
// then switch on, settle, restore and release isolation. All outputs are registered.
module pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int ISO_DLY       = 2,
  parameter int SAVE_DLY      = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int RESTORE_DLY   = 2,
  parameter int ACK_TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwr_down_req,
  input  logic       pwr_up_req,
  input  logic       pwr_sw_ack,
  input  logic       err_clr,
  output logic       pwr_sw_en,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] pwr_state
);

  localparam int MAX_DLY = max_of(max_of(max_of(ISO_DLY, SAVE_DLY),
                                         max_of(SETTLE_CYCLES, RESTORE_DLY)), ACK_TIMEOUT);
  localparam int CNT_W = $clog2(MAX_DLY + 1);

  pwr_seq_state_e state_q, state_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_expire;
  logic             err_set;

  logic       pwr_sw_en_q, pwr_sw_en_d;
  logic       iso_en_q, iso_en_d;
  logic       save_q, save_d;
  logic       restore_q, restore_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [1:0] pwr_state_q, pwr_state_d;

  pwr_seq_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // Requests are levels sampled only in ON/OFF; during a sequence they are ignored,
  // neither queued nor aborting. Only the request relevant to the stable state acts.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    err_set  = 1'b0;
    case (state_q)
      ST_ON: if (pwr_down_req) begin
        state_d = ST_ISO; tmr_load = 1'b1; tmr_val = CNT_W'(ISO_DLY);
      end
      ST_ISO: if (tmr_expire) begin
        state_d = ST_SAVE; tmr_load = 1'b1; tmr_val = CNT_W'(SAVE_DLY);
      end
      ST_SAVE: if (tmr_expire) begin
        state_d = ST_SW_OFF; tmr_load = 1'b1; tmr_val = CNT_W'(ACK_TIMEOUT);
      end
      ST_SW_OFF: begin
        if (!pwr_sw_ack) begin
          state_d = ST_OFF;
        end else if (tmr_expire) begin
          state_d = ST_OFF; err_set = 1'b1;
        end
      end
      ST_OFF: if (pwr_up_req) begin
        state_d = ST_SW_ON; tmr_load = 1'b1; tmr_val = CNT_W'(ACK_TIMEOUT);
      end
      ST_SW_ON: begin
        if (pwr_sw_ack) begin
          state_d = ST_SETTLE; tmr_load = 1'b1; tmr_val = CNT_W'(SETTLE_CYCLES);
        end else if (tmr_expire) begin
          // Failed power-up falls back to OFF with the switch opened again.
          state_d = ST_OFF; err_set = 1'b1;
        end
      end
      ST_SETTLE: if (tmr_expire) begin
        state_d = ST_RESTORE; tmr_load = 1'b1; tmr_val = CNT_W'(RESTORE_DLY);
      end
      ST_RESTORE: if (tmr_expire) state_d = ST_ISO_REL;
      ST_ISO_REL: state_d = ST_ON;
      default:    state_d = ST_ON;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    pwr_sw_en_d = 1'b1;
    iso_en_d    = 1'b1;
    save_d      = 1'b0;
    restore_d   = 1'b0;
    busy_d      = 1'b1;
    pwr_state_d = PS_GOING_DOWN;
    case (state_d)
      ST_ON:      begin iso_en_d = 1'b0; busy_d = 1'b0; pwr_state_d = PS_ON; end
      ST_ISO:     ;
      ST_SAVE:    save_d = 1'b1;
      ST_SW_OFF:  pwr_sw_en_d = 1'b0;
      ST_OFF:     begin pwr_sw_en_d = 1'b0; busy_d = 1'b0; pwr_state_d = PS_OFF; end
      ST_SW_ON:   pwr_state_d = PS_GOING_UP;
      ST_SETTLE:  pwr_state_d = PS_GOING_UP;
      ST_RESTORE: begin restore_d = 1'b1; pwr_state_d = PS_GOING_UP; end
      ST_ISO_REL: begin iso_en_d = 1'b0; pwr_state_d = PS_GOING_UP; end
      default:    begin iso_en_d = 1'b0; busy_d = 1'b0; pwr_state_d = PS_ON; end
    endcase
    done_d = ((state_q == ST_ISO_REL) && (state_d == ST_ON)) ||
             ((state_q == ST_SW_OFF)  && (state_d == ST_OFF));
    err_d  = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ON;
      pwr_sw_en_q <= 1'b1;
      iso_en_q    <= 1'b0;
      save_q      <= 1'b0;
      restore_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pwr_state_q <= PS_ON;
    end else begin
      state_q     <= state_d;
      pwr_sw_en_q <= pwr_sw_en_d;
      iso_en_q    <= iso_en_d;
      save_q      <= save_d;
      restore_q   <= restore_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pwr_state_q <= pwr_state_d;
    end
  end

  assign pwr_sw_en = pwr_sw_en_q;
  assign iso_en    = iso_en_q;
  assign save      = save_q;
  assign restore   = restore_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign pwr_state = pwr_state_q;

endmodule
